// File: rtl/mult_pipe_unit.sv
// mult_pipe_unit: fully pipelined MUL/MULH/MULHSU/MULHU execution unit.
// Each stage retires K = 2*XLEN/NUM_STAGES multiplier bits. The ROB tag and
// function code travel with the data. The last stage registers the selected
// result word. The whole pipe stalls as one when the output is blocked.
module mult_pipe_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 5
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [XLEN-1:0]                   in_opa,
    input  logic [XLEN-1:0]                   in_opb,
    input  logic [1:0]                        in_func,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [XLEN-1:0]                   out_value,
    output logic [TAG_W-1:0]                  out_tag,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

    typedef enum logic [1:0] {
        FN_MUL    = 2'b00,
        FN_MULH   = 2'b01,
        FN_MULHSU = 2'b10,
        FN_MULHU  = 2'b11
    } func_e;

    localparam int W     = 2 * XLEN;
    localparam int K     = W / NUM_STAGES;
    localparam int OCC_W = $clog2(NUM_STAGES + 1);
    localparam logic [W-1:0] K_MASK = {W{1'b1}} >> (W - K);

    logic             advance;
    logic             accept;
    logic             deliver;
    logic [W-1:0]     ext_a;
    logic [W-1:0]     ext_b;
    logic [XLEN-1:0]  result_sel;

    // Stage inputs: stage 0 is fed by the issue port, stage g by register g-1.
    logic [W-1:0]     src_mcand  [NUM_STAGES];
    logic [W-1:0]     src_mplier [NUM_STAGES];
    logic [W-1:0]     src_prod   [NUM_STAGES];
    logic [W-1:0]     sum_prod   [NUM_STAGES];
    logic [1:0]       src_func   [NUM_STAGES];
    logic [TAG_W-1:0] src_tag    [NUM_STAGES];
    logic             src_valid  [NUM_STAGES];

    // Inter-stage registers; the last stage lives in out_valid/out_value/out_tag.
    logic [W-1:0]     stg_mcand  [NUM_STAGES];
    logic [W-1:0]     stg_mplier [NUM_STAGES];
    logic [W-1:0]     stg_prod   [NUM_STAGES];
    logic [1:0]       stg_func   [NUM_STAGES];
    logic [TAG_W-1:0] stg_tag    [NUM_STAGES];
    logic             stg_valid  [NUM_STAGES];

    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance & ~flush;
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready;

    // Extend operands to 2*XLEN according to the signedness of each function.
    always_comb begin
        ext_a = {{XLEN{in_opa[XLEN-1]}}, in_opa};
        if (in_func == FN_MULHU) ext_a = {{XLEN{1'b0}}, in_opa};
        ext_b = {{XLEN{in_opb[XLEN-1]}}, in_opb};
        if (in_func == FN_MULHSU || in_func == FN_MULHU) ext_b = {{XLEN{1'b0}}, in_opb};
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign src_mcand[g]  = ext_a;
            assign src_mplier[g] = ext_b;
            assign src_prod[g]   = '0;
            assign src_func[g]   = in_func;
            assign src_tag[g]    = in_tag;
            assign src_valid[g]  = accept;
        end else begin : g_body
            assign src_mcand[g]  = stg_mcand[g-1];
            assign src_mplier[g] = stg_mplier[g-1];
            assign src_prod[g]   = stg_prod[g-1];
            assign src_func[g]   = stg_func[g-1];
            assign src_tag[g]    = stg_tag[g-1];
            assign src_valid[g]  = stg_valid[g-1];
        end
        // Low K multiplier bits times the (already shifted) multiplicand, mod 2^W.
        assign sum_prod[g] = src_prod[g] + ((src_mplier[g] & K_MASK) * src_mcand[g]);
    end

    // Pick the low word for MUL, the high word for every other function.
    always_comb begin
        result_sel = sum_prod[NUM_STAGES-1][W-1:XLEN];
        if (src_func[NUM_STAGES-1] == FN_MUL) result_sel = sum_prod[NUM_STAGES-1][XLEN-1:0];
    end

    // Pipeline advance, flush squash, output register and occupancy count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                stg_valid[i]  <= 1'b0;
                stg_mcand[i]  <= '0;
                stg_mplier[i] <= '0;
                stg_prod[i]   <= '0;
                stg_func[i]   <= '0;
                stg_tag[i]    <= '0;
            end
            out_valid <= 1'b0;
            out_value <= '0;
            out_tag   <= '0;
            occupancy <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) stg_valid[i] <= 1'b0;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            if (advance) begin
                // Data only loads behind a valid bit, so bubbles leave stale data untouched.
                for (int unsigned i = 0; i < NUM_STAGES - 1; i++) begin
                    stg_valid[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        stg_mcand[i]  <= src_mcand[i] << K;
                        stg_mplier[i] <= src_mplier[i] >> K;
                        stg_prod[i]   <= sum_prod[i];
                        stg_func[i]   <= src_func[i];
                        stg_tag[i]    <= src_tag[i];
                    end
                end
                out_valid <= src_valid[NUM_STAGES-1];
                if (src_valid[NUM_STAGES-1]) begin
                    out_value <= result_sel;
                    out_tag   <= src_tag[NUM_STAGES-1];
                end
            end
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(deliver);
        end
    end

endmodule
